// File: rtl/timer_irq_pkg.sv
// Shared definitions for the timer_irq peripheral: FSM state encodings and
// control-register bit positions.
package timer_irq_pkg;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_PER     = 1;
  localparam int unsigned CTRL_DIV_LSB = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/timer_irq_presc.sv
// Prescaler for timer_irq: counts 0..div while run is high and flags the
// last count of each period with tick.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart the period from 0 (dominates run)
//   run        : count enable; the counter holds while low
//   div        : divisor, tick period is div+1 cycles
//   tick       : high in the cycle where the counter equals div
module timer_irq_presc #(
  parameter int unsigned PSEL_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              run,
  input  logic [PSEL_W-1:0] div,
  output logic              tick
);

  logic [PSEL_W-1:0] presc_q, presc_d;

  assign tick = run && (presc_q == div);

  // Next prescaler value.
  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (run) begin
      presc_d = tick ? '0 : presc_q + PSEL_W'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/timer_irq.sv
// Programmable down-counting timer with level interrupt, driven by CPU
// output-port writes and read back through a CPU input port.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   we_load, we_ctrl : write strobes for the reload and control registers
//   wdata            : write data shared by both registers
//   ack              : end-of-interrupt pulse, clears irq
//   count            : current count
//   irq              : level interrupt request
//   overrun          : sticky, expiry while irq was still pending
//   running          : timer is in the RUN state
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned PSEL_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_load,
  input  logic             we_ctrl,
  input  logic [7:0]       wdata,
  input  logic             ack,
  output logic [WIDTH-1:0] count,
  output logic             irq,
  output logic             overrun,
  output logic             running
);

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  reload_q, reload_d;
  logic [WIDTH-1:0]  count_q, count_d;
  logic              irq_q, irq_d;
  logic              ovr_q, ovr_d;

  logic presc_clr;
  logic run;
  logic tick;
  logic wr;
  logic expire;
  logic dec;

  assign run     = (state_q == ST_RUN) && ctrl_q[CTRL_EN];
  assign wr      = we_load || we_ctrl;
  // Any register write in the same cycle swallows the tick.
  assign expire  = tick && (count_q == '0) && !wr;
  assign dec     = tick && (count_q != '0) && !wr;

  assign count   = count_q;
  assign irq     = irq_q;
  assign overrun = ovr_q;
  assign running = (state_q == ST_RUN);

  timer_irq_presc #(
    .PSEL_W (PSEL_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .clr   (presc_clr),
    .run   (run),
    .div   (ctrl_q[CTRL_DIV_LSB +: PSEL_W]),
    .tick  (tick)
  );

  // Next-state and register update logic.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    reload_d  = reload_q;
    count_d   = count_q;
    irq_d     = irq_q;
    ovr_d     = ovr_q;
    presc_clr = 1'b0;

    if (we_load) begin
      reload_d  = wdata[WIDTH-1:0];
      count_d   = wdata[WIDTH-1:0];
      presc_clr = 1'b1;
    end

    if (we_ctrl) begin
      ctrl_d = wdata;
      if (wdata[CTRL_EN]) begin
        presc_clr = 1'b1;
        state_d   = ST_RUN;
      end else begin
        state_d = ST_IDLE;
        ovr_d   = 1'b0;
      end
    end

    if (dec) begin
      count_d = count_q - WIDTH'(1);
    end

    // A new expiry wins over a simultaneous ack.
    if (expire) begin
      irq_d = 1'b1;
      if (irq_q && !ack) begin
        ovr_d = 1'b1;
      end
      if (ctrl_q[CTRL_PER]) begin
        count_d = reload_q;
      end else begin
        ctrl_d[CTRL_EN] = 1'b0;
        state_d         = ST_IDLE;
      end
    end else if (ack) begin
      irq_d = 1'b0;
    end
  end

  // State and register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      reload_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
      ovr_q    <= ovr_d;
    end
  end

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: stimulus is driven on the falling edge,
// the expected post-edge outputs are queued, and a checker pops and compares
// them just after each rising edge.
module tb_timer_irq;

  logic       clk;
  logic       reset;
  logic       we_load;
  logic       we_ctrl;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] count;
  logic       irq;
  logic       overrun;
  logic       running;

  int total = 0;
  int bad   = 0;
  int tid   = 0;
  int sidx  = 0;

  typedef struct {
    logic       chk;
    logic [7:0] count;
    logic       irq;
    logic       ovr;
    logic       run;
    int         tid;
    int         sidx;
  } exp_t;

  typedef struct {
    logic       ld;
    logic       ct;
    logic [7:0] wd;
    logic       ack;
    logic [7:0] count;
    logic       irq;
    logic       ovr;
    logic       run;
  } vec_t;

  exp_t sb[$];

  timer_irq #(
    .WIDTH  (8),
    .PSEL_W (6)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .we_load (we_load),
    .we_ctrl (we_ctrl),
    .wdata   (wdata),
    .ack     (ack),
    .count   (count),
    .irq     (irq),
    .overrun (overrun),
    .running (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input int t, input int s, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL t%0d step%0d %s got=%0d want=%0d", t, s, nm, got, want);
    end
  endtask

  // Checker: one queued expectation per clock edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk) begin
        cmp("count",   e.tid, e.sidx, int'(count),   int'(e.count));
        cmp("irq",     e.tid, e.sidx, int'(irq),     int'(e.irq));
        cmp("overrun", e.tid, e.sidx, int'(overrun), int'(e.ovr));
        cmp("running", e.tid, e.sidx, int'(running), int'(e.run));
      end
    end
  end

  task automatic step(input logic rst, input logic ld, input logic ct, input logic [7:0] wd,
                      input logic a, input logic chk, input logic [7:0] ec,
                      input logic ei, input logic eo, input logic er);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    we_load = ld;
    we_ctrl = ct;
    wdata   = wd;
    ack     = a;
    sidx++;
    e.chk = chk; e.count = ec; e.irq = ei; e.ovr = eo; e.run = er;
    e.tid = tid; e.sidx = sidx;
    sb.push_back(e);
  endtask

  task automatic idle(input logic [7:0] ec, input logic ei, input logic eo, input logic er);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, ec, ei, eo, er);
  endtask

  vec_t t2[10];
  logic irq_m;
  logic a;
  int   tk;

  initial begin
    reset = 1'b1; we_load = 1'b0; we_ctrl = 1'b0; wdata = 8'h00; ack = 1'b0;

    // one-shot countdown from 3, div=0, then ack
    t2[0] = '{1'b1, 1'b0, 8'h03, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0};
    t2[1] = '{1'b0, 1'b1, 8'h01, 1'b0, 8'd3, 1'b0, 1'b0, 1'b1};
    t2[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'd2, 1'b0, 1'b0, 1'b1};
    t2[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'd1, 1'b0, 1'b0, 1'b1};
    t2[4] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
    t2[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    t2[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    t2[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0};
    t2[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};
    t2[9] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};

    // 1: reset and quiet hold
    tid = 1;
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) idle(8'd0, 1'b0, 1'b0, 1'b0);

    // 2: table-driven one-shot
    tid = 2;
    for (int i = 0; i < 10; i++)
      step(1'b0, t2[i].ld, t2[i].ct, t2[i].wd, t2[i].ack, 1'b1,
           t2[i].count, t2[i].irq, t2[i].ovr, t2[i].run);

    // 3: periodic, reload=2, div=3 -> expiry every 12 cycles
    tid = 3;
    step(1'b0, 1'b1, 1'b0, 8'h02, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b1);
    irq_m = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      a  = (n == 16) || (n == 26);
      tk = n / 4;
      if (n % 12 == 0) irq_m = 1'b1;
      else if (a) irq_m = 1'b0;
      step(1'b0, 1'b0, 1'b0, 8'h00, a, 1'b1, 8'(2 - (tk % 3)), irq_m, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
    idle(8'd1, 1'b0, 1'b0, 1'b0);

    // 4: reload=0, div=0, periodic, never ack -> overrun; ctrl=0 clears it
    tid = 4;
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    idle(8'd0, 1'b1, 1'b0, 1'b1);
    idle(8'd0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
    idle(8'd0, 1'b1, 1'b0, 1'b0);

    // 5a: ack coinciding with expiry keeps irq, no overrun
    tid = 5;
    step(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'd0, 1'b1, 1'b0, 1'b1);
    idle(8'd0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    // ack with irq low has no effect
    step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    // 5b: load in the expiry cycle suppresses the expiry
    step(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 1'b1);
    idle(8'd4, 1'b0, 1'b0, 1'b1);

    // 6: reset mid-count, then restart from count=0
    tid = 6;
    step(1'b0, 1'b1, 1'b0, 8'h09, 1'b0, 1'b1, 8'd9, 1'b0, 1'b0, 1'b1);
    idle(8'd8, 1'b0, 1'b0, 1'b1);
    idle(8'd7, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    idle(8'd0, 1'b1, 1'b0, 1'b0);
    // simultaneous load and ctrl writes both apply
    step(1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b1);
    idle(8'd2, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    we_load = 1'b0; we_ctrl = 1'b0; ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
